// File: rtl/pid_pkg.sv
// Shared types, defaults and helpers for the PID datapath blocks.
// Combinational only; no latency, no flow control.
package pid_pkg;

    localparam int W_DEF   = 15;
    localparam int DW_DEF  = 15;
    localparam int NCH_DEF = 2;

    localparam logic signed [W_DEF-1:0] UMAX_DEF   = 15'sd8191;
    localparam logic signed [W_DEF-1:0] UMIN_DEF   = -15'sd8192;
    localparam logic signed [W_DEF-1:0] UINIT_DEF  = 15'sd0;
    localparam logic signed [W_DEF-1:0] DU_MAX_DEF = 15'sd512;

    typedef struct packed {
        logic                    sat_hi;
        logic                    sat_lo;
        logic signed [W_DEF-1:0] result;
    } sat_res_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One guard bit makes the sum exact, so clamping never sees a wrapped value.
    function automatic sat_res_t sat_add(input logic signed [W_DEF-1:0] acc,
                                         input logic signed [W_DEF-1:0] du,
                                         input logic signed [W_DEF-1:0] umin,
                                         input logic signed [W_DEF-1:0] umax);
        logic signed [W_DEF:0] sum;
        sat_res_t r;
        sum = $signed({acc[W_DEF-1], acc}) + $signed({du[W_DEF-1], du});
        r.sat_hi = 1'b0;
        r.sat_lo = 1'b0;
        r.result = sum[W_DEF-1:0];
        if (sum > $signed({umax[W_DEF-1], umax})) begin
            r.result = umax;
            r.sat_hi = 1'b1;
        end else if (sum < $signed({umin[W_DEF-1], umin})) begin
            r.result = umin;
            r.sat_lo = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pid_sat_add.sv
// Signed W+1-bit add with clamp to [umin, umax] and saturation flags.
// Purely combinational; no backpressure.
module pid_sat_add #(
    parameter int W = 15
) (
    input  logic signed [W-1:0] acc,
    input  logic signed [W-1:0] du,
    input  logic signed [W-1:0] umin,
    input  logic signed [W-1:0] umax,
    output logic signed [W-1:0] result,
    output logic                sat_hi,
    output logic                sat_lo
);

    logic signed [W:0] sum;
    logic signed [W:0] hi_lim;
    logic signed [W:0] lo_lim;

    assign sum    = $signed({acc[W-1], acc}) + $signed({du[W-1], du});
    assign hi_lim = $signed({umax[W-1], umax});
    assign lo_lim = $signed({umin[W-1], umin});

    always_comb begin
        result = sum[W-1:0];
        sat_hi = 1'b0;
        sat_lo = 1'b0;
        if (sum > hi_lim) begin
            result = umax;
            sat_hi = 1'b1;
        end else if (sum < lo_lim) begin
            result = umin;
            sat_lo = 1'b1;
        end
    end

endmodule

// File: rtl/pid_uk_accum.sv
// Multi-channel incremental-PID accumulator u_k = clamp(u_k-1 + du_k); optional slew clip via PID_SLEW_LIMIT_EN.
// Latency 1 cycle; one strobe per cycle, no stall. clr has priority and drops a same-cycle du (upstream re-issues).
module pid_uk_accum
    import pid_pkg::*;
#(
    parameter int                     NCH    = NCH_DEF,
    parameter int                     CHW    = 1,
    parameter int                     W      = W_DEF,
    parameter int                     DW     = DW_DEF,
    parameter logic signed [W-1:0]    UMAX   = UMAX_DEF,
    parameter logic signed [W-1:0]    UMIN   = UMIN_DEF,
    parameter logic signed [W-1:0]    UINIT  = UINIT_DEF,
    parameter logic signed [W-1:0]    DU_MAX = DU_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  du_valid,
    input  logic [CHW-1:0]        du_ch,
    input  logic signed [DW-1:0]  du,
    input  logic                  clr,
    input  logic [CHW-1:0]        clr_ch,
    input  logic                  hold,
    output logic                  uk_valid,
    output logic [CHW-1:0]        uk_ch,
    output logic signed [W-1:0]   uk,
    output logic                  sat_hi,
    output logic                  sat_lo,
`ifdef PID_SLEW_LIMIT_EN
    output logic                  slew_clip,
`endif
    output logic [NCH*W-1:0]      uk_all
);

    logic signed [W-1:0] acc [NCH];
    logic                du_in_range;
    logic                clr_in_range;
    logic                accept;
    logic signed [W-1:0] acc_rd;
    logic signed [W-1:0] du_w;
    logic signed [W-1:0] du_c;
    logic                du_clipped;
    logic signed [W-1:0] sum_res;
    logic                sum_hi;
    logic                sum_lo;

    assign du_in_range  = int'(du_ch) < NCH;
    assign clr_in_range = int'(clr_ch) < NCH;
    assign accept       = du_valid && !hold && du_in_range;
    assign du_w         = W'(du);

    always_comb begin
        acc_rd = acc[0];
        if (du_in_range) acc_rd = acc[du_ch];
    end

`ifdef PID_SLEW_LIMIT_EN
    always_comb begin
        du_c       = du_w;
        du_clipped = 1'b0;
        if (du_w > DU_MAX) begin
            du_c       = DU_MAX;
            du_clipped = 1'b1;
        end else if (du_w < -DU_MAX) begin
            du_c       = -DU_MAX;
            du_clipped = 1'b1;
        end
    end
`else
    assign du_c       = du_w;
    assign du_clipped = 1'b0;
`endif

    pid_sat_add #(.W(W)) u_sat_add (
        .acc    (acc_rd),
        .du     (du_c),
        .umin   (UMIN),
        .umax   (UMAX),
        .result (sum_res),
        .sat_hi (sum_hi),
        .sat_lo (sum_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) acc[i] <= UINIT;
            uk_valid <= 1'b0;
            uk_ch    <= '0;
            uk       <= UINIT;
            sat_hi   <= 1'b0;
            sat_lo   <= 1'b0;
`ifdef PID_SLEW_LIMIT_EN
            slew_clip <= 1'b0;
`endif
        end else begin
            uk_valid <= 1'b0;
            if (clr && clr_in_range) begin
                acc[clr_ch] <= UINIT;
                uk_valid    <= 1'b1;
                uk_ch       <= clr_ch;
                uk          <= UINIT;
                sat_hi      <= 1'b0;
                sat_lo      <= 1'b0;
`ifdef PID_SLEW_LIMIT_EN
                slew_clip   <= 1'b0;
`endif
            end else if (accept) begin
                acc[du_ch] <= sum_res;
                uk_valid   <= 1'b1;
                uk_ch      <= du_ch;
                uk         <= sum_res;
                sat_hi     <= sum_hi;
                sat_lo     <= sum_lo;
`ifdef PID_SLEW_LIMIT_EN
                slew_clip  <= du_clipped;
`endif
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_all
        assign uk_all[g*W +: W] = acc[g];
    end

endmodule

// File: tb/tb_pid_uk_accum.sv
// Randomised and directed check of pid_uk_accum against an integer reference model.
module tb_pid_uk_accum;

    localparam int NCH = 2;
    localparam int CHW = 1;
    localparam int W   = 15;
    localparam int DW  = 15;
    localparam int UMAX_I   = 8191;
    localparam int UMIN_I   = -8192;
    localparam int UINIT_I  = 0;
    localparam int DU_MAX_I = 512;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 du_valid;
    logic [CHW-1:0]       du_ch;
    logic signed [DW-1:0] du;
    logic                 clr;
    logic [CHW-1:0]       clr_ch;
    logic                 hold;
    logic                 uk_valid;
    logic [CHW-1:0]       uk_ch;
    logic signed [W-1:0]  uk;
    logic                 sat_hi;
    logic                 sat_lo;
    logic                 slew_clip_o;
    logic [NCH*W-1:0]     uk_all;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    int m_acc [NCH];
    int e_valid, e_ch, e_uk, e_hi, e_lo, e_clip;

    always #5 clk = ~clk;

    pid_uk_accum #(
        .NCH(NCH), .CHW(CHW), .W(W), .DW(DW),
        .UMAX(15'sd8191), .UMIN(-15'sd8192), .UINIT(15'sd0), .DU_MAX(15'sd512)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .du_valid (du_valid),
        .du_ch    (du_ch),
        .du       (du),
        .clr      (clr),
        .clr_ch   (clr_ch),
        .hold     (hold),
        .uk_valid (uk_valid),
        .uk_ch    (uk_ch),
        .uk       (uk),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo),
`ifdef PID_SLEW_LIMIT_EN
        .slew_clip(slew_clip_o),
`endif
        .uk_all   (uk_all)
    );

`ifndef PID_SLEW_LIMIT_EN
    assign slew_clip_o = 1'b0;
`endif

    // Reference: plain integer arithmetic on the rules; clr beats du, hold only gates du.
    always @(posedge clk) begin
        int d, s;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) m_acc[i] = UINIT_I;
            e_valid = 0; e_ch = 0; e_uk = UINIT_I; e_hi = 0; e_lo = 0; e_clip = 0;
        end else begin
            e_valid = 0;
            if (clr) begin
                m_acc[clr_ch] = UINIT_I;
                e_valid = 1; e_ch = clr_ch; e_uk = UINIT_I; e_hi = 0; e_lo = 0; e_clip = 0;
            end else if (du_valid && !hold) begin
                d = du;
                e_clip = 0;
`ifdef PID_SLEW_LIMIT_EN
                if (d > DU_MAX_I) begin d = DU_MAX_I; e_clip = 1; end
                else if (d < -DU_MAX_I) begin d = -DU_MAX_I; e_clip = 1; end
`endif
                s = m_acc[du_ch] + d;
                e_hi = 0; e_lo = 0;
                if (s > UMAX_I) begin s = UMAX_I; e_hi = 1; end
                else if (s < UMIN_I) begin s = UMIN_I; e_lo = 1; end
                m_acc[du_ch] = s;
                e_valid = 1; e_ch = du_ch; e_uk = s;
            end
        end
    end

    task automatic cmp(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("uk_valid", int'(uk_valid), e_valid);
            cmp("uk_ch", int'(uk_ch), e_ch);
            cmp("uk", int'(uk), e_uk);
            cmp("sat_hi", int'(sat_hi), e_hi);
            cmp("sat_lo", int'(sat_lo), e_lo);
`ifdef PID_SLEW_LIMIT_EN
            cmp("slew_clip", int'(slew_clip_o), e_clip);
`endif
            for (int i = 0; i < NCH; i++)
                cmp("uk_all", int'($signed(uk_all[i*W +: W])), m_acc[i]);
        end
    end

    task automatic drive(input bit v, input int ch, input int d,
                         input bit c, input int cch, input bit h);
        du_valid = v;
        du_ch    = ch[CHW-1:0];
        du       = d[DW-1:0];
        clr      = c;
        clr_ch   = cch[CHW-1:0];
        hold     = h;
        @(posedge clk);
        #1;
    endtask

    function automatic int ch_val(input int i);
        return int'($signed(uk_all[i*W +: W]));
    endfunction

    initial begin
        int d;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check_en = 1'b1;
        cmp("rst_valid", int'(uk_valid), 0);
        cmp("rst_uk", int'(uk), 0);
        cmp("rst_all", int'(uk_all), 0);
        rst_n = 1'b1;

        drive(1, 0, 100, 0, 0, 0);  cmp("b2b_1", int'(uk), 100);
        drive(1, 0, 100, 0, 0, 0);  cmp("b2b_2", int'(uk), 200);
        drive(1, 0, 100, 0, 0, 0);  cmp("b2b_3", int'(uk), 300);
        cmp("b2b_valid", int'(uk_valid), 1);
        cmp("b2b_ch1", ch_val(1), 0);

`ifndef PID_SLEW_LIMIT_EN
        drive(1, 1, 8100, 0, 0, 0);
        drive(1, 1, 200, 0, 0, 0);  cmp("hi_uk", int'(uk), 8191);
        cmp("hi_flag", int'(sat_hi), 1);
        drive(1, 1, -91, 0, 0, 0);  cmp("hi_back", int'(uk), 8100);
        cmp("hi_clear", int'(sat_hi), 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, -8000, 0, 0, 0);
        drive(1, 0, -16384, 0, 0, 0); cmp("lo_uk", int'(uk), -8192);
        cmp("lo_flag", int'(sat_lo), 1);
`else
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, 1000, 0, 0, 0); cmp("slew_uk", int'(uk), 512);
        cmp("slew_flag", int'(slew_clip_o), 1);
        drive(1, 0, 10, 0, 0, 0);   cmp("slew_uk2", int'(uk), 522);
        cmp("slew_flag2", int'(slew_clip_o), 0);
`endif

        drive(1, 0, 50, 1, 0, 0);   cmp("clr_uk", int'(uk), 0);
        cmp("clr_ch", int'(uk_ch), 0);
        cmp("clr_valid", int'(uk_valid), 1);
        drive(1, 0, 10, 0, 0, 1);   cmp("hold_valid", int'(uk_valid), 0);
        cmp("hold_acc", ch_val(0), 0);
        drive(1, 1, 7, 1, 0, 0);    cmp("clr_xch", int'(uk_ch), 0);

        drive(1, 0, 5, 0, 0, 0);
        rst_n = 1'b0;
        drive(1, 0, 5, 0, 0, 0);    cmp("mid_rst_valid", int'(uk_valid), 0);
        cmp("mid_rst_all", int'(uk_all), 0);
        rst_n = 1'b1;
        drive(1, 0, 5, 0, 0, 0);    cmp("post_rst", int'(uk), 5);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom_range(0, 32767);
                d = d - 16384;
            end else begin
                d = $urandom_range(0, 1400);
                d = d - 700;
            end
            rst_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, NCH - 1), d,
                  $urandom_range(0, 11) == 0, $urandom_range(0, NCH - 1),
                  $urandom_range(0, 7) == 0);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
